// File: rtl/delay_line_if.sv
// rtl/delay_line_if.sv - stream/control bundle between a delay_line and its user
//
// Purpose: groups shift control, input sample, tap select and tap outputs.
// Signals:
//   ce       shift enable (user -> line)
//   flush    synchronous clear of data, valid and fill (user -> line)
//   d        input data, N bits (user -> line)
//   d_valid  valid flag travelling with d (user -> line)
//   sel      requested delay in ce-cycles, SEL_W bits (user -> line)
//   q        data at selected tap (line -> user)
//   q_valid  valid flag at selected tap (line -> user)
//   fill     ce-shifts since reset/flush, saturating at DEPTH (line -> user)
//   primed   fill >= effective tap (line -> user)
interface delay_line_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic             ce;
    logic             flush;
    logic [N-1:0]     d;
    logic             d_valid;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     q;
    logic             q_valid;
    logic [SEL_W-1:0] fill;
    logic             primed;

    modport master (
        output ce, flush, d, d_valid, sel,
        input  q, q_valid, fill, primed
    );

    modport slave (
        input  ce, flush, d, d_valid, sel,
        output q, q_valid, fill, primed
    );
endinterface

// File: rtl/delay_line.sv
// rtl/delay_line.sv - multi-stage enabled delay line with valid, flush and selectable tap
//
// Purpose: DEPTH register stages of {data, valid} advancing on ce; the output
// taps stage k where k is sel clamped to 1..DEPTH. A saturating fill counter
// reports how many shifts have happened since reset/flush, and primed says
// whether the selected tap has been reached by real shifts yet.
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  synchronous active-low reset
//   bus    delay_line_if slave modport (ce, flush, d, d_valid, sel in;
//          q, q_valid, fill, primed out)
module delay_line #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    delay_line_if.slave  bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam logic [SEL_W-1:0] DEPTH_S = SEL_W'(DEPTH);
    localparam logic [SEL_W-1:0] ONE_S   = SEL_W'(1);

    logic [N-1:0]     data_q [1:DEPTH];
    logic             vld_q  [1:DEPTH];
    logic [SEL_W-1:0] fill_q;
    logic [SEL_W-1:0] fill_d;
    logic [SEL_W-1:0] tap;
    logic [N-1:0]     q_mux;
    logic             v_mux;

    // Reset and flush clear identically; flush wins over ce so a sample
    // presented on the flush edge is discarded.
    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
        if (i == 1) begin : g_head
            always_ff @(posedge clk) begin
                if (!rst_n || bus.flush) begin
                    data_q[i] <= '0;
                    vld_q[i]  <= 1'b0;
                end else if (bus.ce) begin
                    data_q[i] <= bus.d;
                    vld_q[i]  <= bus.d_valid;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (!rst_n || bus.flush) begin
                    data_q[i] <= '0;
                    vld_q[i]  <= 1'b0;
                end else if (bus.ce) begin
                    data_q[i] <= data_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                end
            end
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (bus.ce && (fill_q != DEPTH_S)) begin
            fill_d = fill_q + ONE_S;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // sel 0 means "one stage"; anything past the end selects the last stage.
    always_comb begin
        tap = bus.sel;
        if (bus.sel == '0) begin
            tap = ONE_S;
        end else if (bus.sel > DEPTH_S) begin
            tap = DEPTH_S;
        end
    end

    // Output mux reads registers only; sel is the sole combinational input.
    always_comb begin
        q_mux = '0;
        v_mux = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (tap == SEL_W'(i)) begin
                q_mux = data_q[i];
                v_mux = vld_q[i];
            end
        end
    end

    assign bus.q       = q_mux;
    assign bus.q_valid = v_mux;
    assign bus.fill    = fill_q;
    assign bus.primed  = (fill_q >= tap);
endmodule

// File: tb/tb_delay_line.sv
// tb/tb_delay_line.sv - scoreboard bench for delay_line (N=8, DEPTH=4)
module tb_delay_line;
    logic clk;
    logic rst_n;

    delay_line_if #(.N(8), .DEPTH(4)) bus ();

    delay_line #(.N(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] q;
        logic       v;
        logic [2:0] f;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are sampled just after each rising edge and compared
    // against the record queued for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q",       bus.q,                e.q);
                check("q_valid", {7'd0, bus.q_valid},  {7'd0, e.v});
                check("fill",    {5'd0, bus.fill},     {5'd0, e.f});
                check("primed",  {7'd0, bus.primed},   {7'd0, e.p});
            end
        end
    end

    // Drive one edge's inputs and queue the outputs expected after that edge.
    task automatic step(input bit rn, input bit fl, input bit c,
                        input logic [7:0] dd, input bit dv, input logic [2:0] s,
                        input logic [7:0] eq, input bit ev, input logic [2:0] ef, input bit ep);
        exp_t e;
        @(negedge clk);
        rst_n       = rn;
        bus.flush   = fl;
        bus.ce      = c;
        bus.d       = dd;
        bus.d_valid = dv;
        bus.sel     = s;
        e.q = eq; e.v = ev; e.f = ef; e.p = ep;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; bus.flush = 1'b0; bus.ce = 1'b0;
        bus.d = 8'h00; bus.d_valid = 1'b0; bus.sel = 3'd3;
        //    rn fl ce d      dv sel  q      v  fill p
        step(0, 0, 1, 8'hEE, 1, 3, 8'h00, 0, 0, 0);
        step(0, 0, 1, 8'hEE, 1, 3, 8'h00, 0, 0, 0);
        // reset and priming, sel=3
        step(1, 0, 1, 8'h11, 1, 3, 8'h00, 0, 1, 0);
        step(1, 0, 1, 8'h22, 1, 3, 8'h00, 0, 2, 0);
        step(1, 0, 1, 8'h33, 1, 3, 8'h11, 1, 3, 1);
        step(1, 0, 1, 8'h44, 1, 3, 8'h22, 1, 4, 1);
        step(1, 0, 1, 8'h55, 1, 3, 8'h33, 1, 4, 1);
        step(1, 0, 1, 8'h66, 1, 3, 8'h44, 1, 4, 1);
        // flush, then ce gating on alternate cycles
        step(1, 1, 1, 8'hFF, 1, 3, 8'h00, 0, 0, 0);
        step(1, 0, 1, 8'hA0, 1, 3, 8'h00, 0, 1, 0);
        step(1, 0, 0, 8'hEE, 1, 3, 8'h00, 0, 1, 0);
        step(1, 0, 1, 8'hA1, 1, 3, 8'h00, 0, 2, 0);
        step(1, 0, 0, 8'hEE, 1, 3, 8'h00, 0, 2, 0);
        step(1, 0, 1, 8'hA2, 1, 3, 8'hA0, 1, 3, 1);
        step(1, 0, 0, 8'hEE, 1, 3, 8'hA0, 1, 3, 1);
        step(1, 0, 1, 8'hA3, 1, 3, 8'hA1, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 3, 8'hA1, 1, 4, 1);
        step(1, 0, 1, 8'hA4, 1, 3, 8'hA2, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 3, 8'hA2, 1, 4, 1);
        step(1, 0, 1, 8'hA5, 1, 3, 8'hA3, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 3, 8'hA3, 1, 4, 1);
        // fill with 0x5x, then flush with ce high and d=FF
        step(1, 0, 1, 8'h50, 1, 3, 8'hA4, 1, 4, 1);
        step(1, 0, 1, 8'h51, 1, 3, 8'hA5, 1, 4, 1);
        step(1, 0, 1, 8'h52, 1, 3, 8'h50, 1, 4, 1);
        step(1, 0, 1, 8'h53, 1, 3, 8'h51, 1, 4, 1);
        step(1, 1, 1, 8'hFF, 1, 3, 8'h00, 0, 0, 0);
        step(1, 0, 1, 8'h00, 0, 3, 8'h00, 0, 1, 0);
        step(1, 0, 1, 8'h00, 0, 3, 8'h00, 0, 2, 0);
        step(1, 0, 1, 8'h00, 0, 3, 8'h00, 0, 3, 1);
        // refill, then reset and flush together
        step(1, 0, 1, 8'h5A, 1, 3, 8'h00, 0, 4, 1);
        step(1, 0, 1, 8'h5B, 1, 3, 8'h00, 0, 4, 1);
        step(1, 0, 1, 8'h5C, 1, 3, 8'h5A, 1, 4, 1);
        step(1, 0, 1, 8'h5D, 1, 3, 8'h5B, 1, 4, 1);
        step(0, 1, 1, 8'hFF, 1, 3, 8'h00, 0, 0, 0);
        // load 04 (oldest) .. 01 (newest), then live tap switching with ce=0
        step(1, 0, 1, 8'h04, 1, 3, 8'h00, 0, 1, 0);
        step(1, 0, 1, 8'h03, 1, 3, 8'h00, 0, 2, 0);
        step(1, 0, 1, 8'h02, 1, 3, 8'h04, 1, 3, 1);
        step(1, 0, 1, 8'h01, 1, 3, 8'h03, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 0, 8'h01, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 2, 8'h02, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 4, 8'h04, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 7, 8'h04, 1, 4, 1);
        step(1, 0, 0, 8'hEE, 1, 1, 8'h01, 1, 4, 1);
        // valid bubbles 1,0,1,1 at sel=2
        step(1, 1, 0, 8'hEE, 1, 2, 8'h00, 0, 0, 0);
        step(1, 0, 1, 8'hB1, 1, 2, 8'h00, 0, 1, 0);
        step(1, 0, 1, 8'hB2, 0, 2, 8'hB1, 1, 2, 1);
        step(1, 0, 1, 8'hB3, 1, 2, 8'hB2, 0, 3, 1);
        step(1, 0, 1, 8'hB4, 1, 2, 8'hB3, 1, 4, 1);
        step(1, 0, 1, 8'hB5, 1, 2, 8'hB4, 1, 4, 1);
        step(1, 0, 1, 8'hB6, 1, 2, 8'hB5, 1, 4, 1);
        // reset mid-stream with ce high, then re-prime at sel=2
        step(0, 0, 1, 8'hC0, 1, 2, 8'h00, 0, 0, 0);
        step(1, 0, 1, 8'hC1, 1, 2, 8'h00, 0, 1, 0);
        step(1, 0, 1, 8'hC2, 1, 2, 8'hC1, 1, 2, 1);
        step(1, 0, 1, 8'hC3, 0, 2, 8'hC2, 1, 3, 1);
        step(1, 0, 1, 8'hC4, 1, 2, 8'hC3, 0, 4, 1);

        @(negedge clk);
        bus.ce = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
